colour_pwm_driver: RTL and testbench

- Consumer end of the 3-bit colour code produced by the button-driven colour cycler.
- Turns the code into three PWM drive signals for an RGB LED: red, green and blue.
- Colour is sampled only at PWM period boundaries, so a change can never cut a pulse short.
- Optional linear fade between colours. Sits between the colour state machine and the board LED pins.

---
 rtl/colour_pwm_driver_if.sv | 23 ++
 rtl/colour_pwm_driver.sv | 85 ++++++++
 tb/tb_colour_pwm_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/colour_pwm_driver_if.sv
// rtl/colour_pwm_driver_if.sv - colour code in, RGB PWM drive and status out
//   colour[2:0], enable       : colour request from the cycler ({B,G,R} code)
//   led_r, led_g, led_b       : registered PWM drives
//   period_tick, settled      : period-start pulse and fade-complete flag
interface colour_pwm_driver_if;
    logic [2:0] colour;
    logic       enable;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       period_tick;
    logic       settled;

    modport master (
        output colour, enable,
        input  led_r, led_g, led_b, period_tick, settled
    );

    modport slave (
        input  colour, enable,
        output led_r, led_g, led_b, period_tick, settled
    );
endinterface

// File: rtl/colour_pwm_driver.sv
// rtl/colour_pwm_driver.sv - 3-bit colour code to three fading RGB PWM drives
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : colour_pwm_driver_if.slave (colour/enable in, leds/status out)
module colour_pwm_driver #(
    parameter int PWM_W   = 8,
    parameter int STEP    = 16,
    parameter bit FADE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    colour_pwm_driver_if.slave    bus
);
    localparam logic [PWM_W-1:0] MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] STEP_V = PWM_W'(STEP);

    // Channel index 0 = red, 1 = green, 2 = blue, matching colour bit order.
    logic [PWM_W-1:0]       cnt_q;
    logic [2:0][PWM_W-1:0]  duty_q;
    logic [2:0][PWM_W-1:0]  duty_d;
    logic [2:0][PWM_W-1:0]  tgt_d;
    logic [2:0]             led_q;
    logic                   period_tick_q;
    logic                   settled_q;
    logic                   settled_d;
    logic                   boundary;

    // Colour is only looked at on the edge that ends a period, so a pulse
    // already in progress always completes with its old duty.
    assign boundary = (cnt_q == MAX);

    // Move duty toward target by at most STEP; the guards keep the
    // arithmetic from ever wrapping.
    function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] d,
                                              input logic [PWM_W-1:0] t);
        logic [PWM_W-1:0] r;
        r = d;
        if (d < t) begin
            r = ((t - d) > STEP_V) ? d + STEP_V : t;
        end else if (d > t) begin
            r = ((d - t) > STEP_V) ? d - STEP_V : t;
        end
        return r;
    endfunction

    always_comb begin
        settled_d = 1'b1;
        tgt_d     = '0;
        duty_d    = '0;
        for (int i = 0; i < 3; i++) begin
            tgt_d[i]  = (bus.enable && bus.colour[i]) ? MAX : '0;
            duty_d[i] = FADE_EN ? ramp(duty_q[i], tgt_d[i]) : tgt_d[i];
            if (duty_d[i] != tgt_d[i]) begin
                settled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            duty_q        <= '0;
            led_q         <= '0;
            period_tick_q <= 1'b0;
            settled_q     <= 1'b1;
        end else begin
            cnt_q         <= cnt_q + 1'b1;
            period_tick_q <= boundary;
            if (boundary) begin
                duty_q    <= duty_d;
                settled_q <= settled_d;
            end
            // Full-scale duty must be solid high; cnt < MAX alone would
            // leave one dark cycle per period.
            for (int i = 0; i < 3; i++) begin
                led_q[i] <= (duty_q[i] == MAX) || (cnt_q < duty_q[i]);
            end
        end
    end

    assign bus.led_r       = led_q[0];
    assign bus.led_g       = led_q[1];
    assign bus.led_b       = led_q[2];
    assign bus.period_tick = period_tick_q;
    assign bus.settled     = settled_q;
endmodule

// File: tb/tb_colour_pwm_driver.sv
// tb/tb_colour_pwm_driver.sv - self-checking bench for colour_pwm_driver
module tb_colour_pwm_driver;
    logic       clk;
    logic       rst_n;
    logic [2:0] colour;
    logic       enable;
    logic       cmp_en;

    int checks   = 0;
    int failures = 0;

    colour_pwm_driver_if if_fade ();
    colour_pwm_driver_if if_jump ();

    assign if_fade.colour = colour;
    assign if_fade.enable = enable;
    assign if_jump.colour = colour;
    assign if_jump.enable = enable;

    colour_pwm_driver #(.PWM_W(4), .STEP(4), .FADE_EN(1'b1)) dut_fade (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fade)
    );

    colour_pwm_driver #(.PWM_W(4), .STEP(4), .FADE_EN(1'b0)) dut_jump (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_jump)
    );

    wire [2:0] led_f = {if_fade.led_b, if_fade.led_g, if_fade.led_r};
    wire [2:0] led_j = {if_jump.led_b, if_jump.led_g, if_jump.led_r};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = fading instance, 1 = jumping instance.
    // Time is tracked as a position within the 16-cycle period.
    int m_pos;
    int m_duty [2][3];
    bit m_led  [2][3];
    bit m_tick [2];
    bit m_settled [2];
    int t_val;
    int delta;
    bit all_eq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0;
            for (int k = 0; k < 2; k++) begin
                m_tick[k]    = 1'b0;
                m_settled[k] = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    m_duty[k][c] = 0;
                    m_led[k][c]  = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 3; c++) begin
                    m_led[k][c] = (m_duty[k][c] == 15) || (m_pos < m_duty[k][c]);
                end
                m_tick[k] = (m_pos == 15);
            end
            if (m_pos == 15) begin
                for (int k = 0; k < 2; k++) begin
                    all_eq = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        t_val = (enable && colour[c]) ? 15 : 0;
                        if (k == 0) begin
                            delta = t_val - m_duty[k][c];
                            if (delta > 4)  delta = 4;
                            if (delta < -4) delta = -4;
                            m_duty[k][c] = m_duty[k][c] + delta;
                        end else begin
                            m_duty[k][c] = t_val;
                        end
                        if (m_duty[k][c] != t_val) all_eq = 1'b0;
                    end
                    m_settled[k] = all_eq;
                end
            end
            m_pos = (m_pos + 1) % 16;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("model_led_fade[%0d]", c), int'(led_f[c]), int'(m_led[0][c]));
                chk($sformatf("model_led_jump[%0d]", c), int'(led_j[c]), int'(m_led[1][c]));
            end
            chk("model_tick_fade", int'(if_fade.period_tick), int'(m_tick[0]));
            chk("model_tick_jump", int'(if_jump.period_tick), int'(m_tick[1]));
            chk("model_settled_fade", int'(if_fade.settled), int'(m_settled[0]));
            chk("model_settled_jump", int'(if_jump.settled), int'(m_settled[1]));
        end
    end

    // Count high cycles per channel over the 16 negedges that follow;
    // ends on the next period_tick negedge.
    task automatic count_period(input int k, input bit scramble,
                                output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (k == 0) begin
                r += int'(led_f[0]); g += int'(led_f[1]); b += int'(led_f[2]);
            end else begin
                r += int'(led_j[0]); g += int'(led_j[1]); b += int'(led_j[2]);
            end
            if (scramble) colour = 3'($urandom);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_fade.period_tick && n < 40);
    endtask

    int r, g, b, n;
    int fade_up [4]  = '{4, 8, 12, 16};
    int fade_dn [4]  = '{11, 7, 3, 0};

    initial begin
        cmp_en = 1'b1;
        colour = 3'b000;
        enable = 1'b1;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_leds", int'(led_f), 0);
        chk("reset_tick", int'(if_fade.period_tick), 0);
        chk("reset_settled", int'(if_fade.settled), 1);
        chk("reset_settled_jump", int'(if_jump.settled), 1);

        // Fade up on red
        @(negedge clk);
        @(negedge clk);
        colour = 3'b001;
        rst_n  = 1'b1;
        wait_tick(n);
        chk("first_tick_delay", n, 16);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("fadeup_settled_p%0d", p), int'(if_fade.settled), (p == 3) ? 1 : 0);
            count_period(0, 1'b0, r, g, b);
            chk($sformatf("fadeup_red_p%0d", p), r, fade_up[p]);
            chk($sformatf("fadeup_green_p%0d", p), g + b, 0);
        end

        // Mid-period change to blue at cnt=5
        repeat (5) @(negedge clk);
        colour = 3'b100;
        r = 0; b = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            r += int'(led_f[0]); b += int'(led_f[2]);
        end
        chk("midchg_red_hold", r, 11);
        chk("midchg_blue_hold", b, 0);
        chk("midchg_tick", int'(if_fade.period_tick), 1);
        chk("midchg_settled", int'(if_fade.settled), 0);
        count_period(0, 1'b0, r, g, b);
        chk("midchg_red", r, 11);
        chk("midchg_blue", b, 4);

        // Settle on white, then drop enable
        colour = 3'b111;
        n = 0;
        do begin
            count_period(0, 1'b0, r, g, b);
            n++;
        end while (!if_fade.settled && n < 8);
        chk("white_settled", int'(if_fade.settled), 1);
        enable = 1'b0;
        count_period(0, 1'b1, r, g, b);
        chk("white_full", r + g + b, 48);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("dis_settled_p%0d", p), int'(if_fade.settled), (p == 3) ? 1 : 0);
            count_period(0, 1'b1, r, g, b);
            chk($sformatf("dis_red_p%0d", p), r, fade_dn[p]);
            chk($sformatf("dis_green_p%0d", p), g, fade_dn[p]);
            chk($sformatf("dis_blue_p%0d", p), b, fade_dn[p]);
        end

        // Jump instance: cyan lands in one period
        enable = 1'b1;
        colour = 3'b110;
        count_period(1, 1'b0, r, g, b);
        chk("jump_settled", int'(if_jump.settled), 1);
        count_period(1, 1'b0, r, g, b);
        chk("jump_red", r, 0);
        chk("jump_green", g, 16);
        chk("jump_blue", b, 16);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)  colour = 3'($urandom);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
        end

        // Async reset mid-fade on red at duty 8
        colour = 3'b000;
        enable = 1'b1;
        wait_tick(n);
        chk("pre_reset_tick", int'(n < 40), 1);
        repeat (5) count_period(0, 1'b0, r, g, b);
        colour = 3'b001;
        repeat (2) count_period(0, 1'b0, r, g, b);
        count_period(0, 1'b0, r, g, b);
        chk("pre_reset_red", r, 8);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_leds", int'(led_f), 0);
        chk("async_settled", int'(if_fade.settled), 1);
        chk("async_tick", int'(if_fade.period_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        chk("rel_tick_delay", n, 16);
        chk("rel_settled", int'(if_fade.settled), 0);
        count_period(0, 1'b0, r, g, b);
        chk("rel_red", r, 4);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
